// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: round-robin issue of two requesters into a shared FPU with a one-entry response buffer
module fpu_issue_ctrl #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_func7,
    input  logic [2:0]       req0_func3,
    input  logic [4:0]       req0_rs2,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_func7,
    input  logic [2:0]       req1_func3,
    input  logic [4:0]       req1_rs2,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [6:0]       fpu_func7,
    output logic [2:0]       fpu_func3,
    output logic [4:0]       fpu_rs2,
    output logic [63:0]      fpu_operand_a,
    output logic [63:0]      fpu_operand_b,
    input  logic [63:0]      fpu_result,
    input  logic [4:0]       fpu_flags,
    input  logic             fpu_cmp,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [63:0]      resp_result,
    output logic [4:0]       resp_flags,
    output logic             resp_cmp,
    output logic             resp_illegal,
    input  logic             csr_we,
    input  logic [2:0]       csr_frm_wdata,
    input  logic [4:0]       csr_fflags_wdata,
    output logic [2:0]       frm,
    output logic [4:0]       fflags,
    output logic [CNT_W-1:0] issue_cnt
);
    logic             any, gid, can_accept, accept, is_cmp, illegal;
    logic [6:0]       s_f7;
    logic [2:0]       s_f3, eff_rm;
    logic [4:0]       s_rs2;
    logic [63:0]      s_a, s_b;
    logic [TAG_W-1:0] s_tag;
    logic             fav_q, fav_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [63:0]      resp_result_q, resp_result_d;
    logic [4:0]       resp_flags_q, resp_flags_d;
    logic             resp_cmp_q, resp_cmp_d;
    logic             resp_illegal_q, resp_illegal_d;
    logic [2:0]       frm_q, frm_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        any        = req0_valid | req1_valid;
        gid        = (req0_valid & req1_valid) ? fav_q : req1_valid;
        can_accept = !resp_valid_q | resp_ready;
        accept     = can_accept & any;
        req0_ready = accept & !gid;
        req1_ready = accept & gid;
        s_f7       = gid ? req1_func7 : req0_func7;
        s_f3       = gid ? req1_func3 : req0_func3;
        s_rs2      = gid ? req1_rs2 : req0_rs2;
        s_a        = gid ? req1_a : req0_a;
        s_b        = gid ? req1_b : req0_b;
        s_tag      = gid ? req1_tag : req0_tag;
        is_cmp     = (s_f7 == 7'b1010000) | (s_f7 == 7'b1010001);
        eff_rm     = (!is_cmp && s_f3 == 3'b111) ? frm_q : s_f3;
        illegal    = !is_cmp & (eff_rm >= 3'd5);
        fpu_func7     = any ? s_f7 : '0;
        fpu_func3     = any ? eff_rm : '0;
        fpu_rs2       = any ? s_rs2 : '0;
        fpu_operand_a = any ? s_a : '0;
        fpu_operand_b = any ? s_b : '0;
    end

    always_comb begin
        fav_d          = accept ? !gid : fav_q;
        resp_valid_d   = accept | (resp_valid_q & !resp_ready);
        resp_id_d      = accept ? gid : resp_id_q;
        resp_tag_d     = accept ? s_tag : resp_tag_q;
        resp_result_d  = accept ? (illegal ? 64'd0 : fpu_result) : resp_result_q;
        resp_flags_d   = accept ? (illegal ? 5'd0 : fpu_flags) : resp_flags_q;
        resp_cmp_d     = accept ? (!illegal & fpu_cmp) : resp_cmp_q;
        resp_illegal_d = accept ? illegal : resp_illegal_q;
        frm_d          = csr_we ? csr_frm_wdata : frm_q;
        fflags_d       = (csr_we ? csr_fflags_wdata : fflags_q) | ((accept & !illegal) ? fpu_flags : 5'd0);
        cnt_d          = (accept && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fav_q          <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_tag_q     <= '0;
            resp_result_q  <= '0;
            resp_flags_q   <= '0;
            resp_cmp_q     <= 1'b0;
            resp_illegal_q <= 1'b0;
            frm_q          <= '0;
            fflags_q       <= '0;
            cnt_q          <= '0;
        end else begin
            fav_q          <= fav_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_tag_q     <= resp_tag_d;
            resp_result_q  <= resp_result_d;
            resp_flags_q   <= resp_flags_d;
            resp_cmp_q     <= resp_cmp_d;
            resp_illegal_q <= resp_illegal_d;
            frm_q          <= frm_d;
            fflags_q       <= fflags_d;
            cnt_q          <= cnt_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_tag     = resp_tag_q;
    assign resp_result  = resp_result_q;
    assign resp_flags   = resp_flags_q;
    assign resp_cmp     = resp_cmp_q;
    assign resp_illegal = resp_illegal_q;
    assign frm          = frm_q;
    assign fflags       = fflags_q;
    assign issue_cnt    = cnt_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized and directed checks against a transaction-level model with a stand-in FPU
module tb_fpu_issue_ctrl;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;
    localparam logic [6:0] FADD_S = 7'b0000000;
    localparam logic [6:0] FCMP_S = 7'b1010000;

    logic clk = 1'b0, rst = 1'b0;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0] req0_func7, req1_func7, fpu_func7;
    logic [2:0] req0_func3, req1_func3, fpu_func3;
    logic [4:0] req0_rs2, req1_rs2, fpu_rs2;
    logic [63:0] req0_a, req0_b, req1_a, req1_b, fpu_operand_a, fpu_operand_b, fpu_result;
    logic [TAG_W-1:0] req0_tag, req1_tag, resp_tag;
    logic [4:0] fpu_flags, resp_flags, csr_fflags_wdata, fflags;
    logic fpu_cmp, resp_valid, resp_ready, resp_id, resp_cmp, resp_illegal, csr_we;
    logic [63:0] resp_result;
    logic [2:0] csr_frm_wdata, frm;
    logic [CNT_W-1:0] issue_cnt;

    int pass_cnt = 0, total_cnt = 0;

    // model state
    logic m_valid, m_id, m_cmp, m_ill, m_fav;
    logic [TAG_W-1:0] m_tag;
    logic [63:0] m_res;
    logic [4:0] m_flags, m_fflags;
    logic [2:0] m_frm;
    int m_cnt;
    logic p_any, p_acc, p_gid, p_ill;
    logic [2:0] p_rm;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func7(req0_func7), .req0_func3(req0_func3),
        .req0_rs2(req0_rs2), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func7(req1_func7), .req1_func3(req1_func3),
        .req1_rs2(req1_rs2), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .fpu_func7(fpu_func7), .fpu_func3(fpu_func3), .fpu_rs2(fpu_rs2),
        .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_cmp(fpu_cmp),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_tag(resp_tag),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_cmp(resp_cmp), .resp_illegal(resp_illegal),
        .csr_we(csr_we), .csr_frm_wdata(csr_frm_wdata), .csr_fflags_wdata(csr_fflags_wdata),
        .frm(frm), .fflags(fflags), .issue_cnt(issue_cnt)
    );

    // stand-in FPU: known single-precision cases, otherwise an arbitrary mixing function
    function automatic logic [69:0] fake_fpu(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs2,
                                             input logic [63:0] a, input logic [63:0] b);
        if (a == 64'h3F800000 && b == 64'h40000000) return {64'h40400000, 5'b00000, 1'b0};
        if (a == 64'h7F7FFFFF && b == 64'h7F7FFFFF) return {64'h7F800000, 5'b00101, 1'b0};
        if (a == 64'h3F800000 && b == 64'h33800000) return {64'h3F800000, 5'b00001, 1'b0};
        return {(a + b) ^ {49'd0, f7, f3, rs2}, a[4:0] ^ b[9:5], a < b};
    endfunction

    assign {fpu_result, fpu_flags, fpu_cmp} = fake_fpu(fpu_func7, fpu_func3, fpu_rs2, fpu_operand_a, fpu_operand_b);

    task automatic predict();
        logic [6:0] f7;
        logic [2:0] f3;
        logic cmp;
        p_any = req0_valid | req1_valid;
        p_gid = (req0_valid && req1_valid) ? m_fav : req1_valid;
        p_acc = p_any && (!m_valid || resp_ready);
        f7 = p_gid ? req1_func7 : req0_func7;
        f3 = p_gid ? req1_func3 : req0_func3;
        cmp = (f7 == 7'h50) || (f7 == 7'h51);
        p_rm = (!cmp && f3 == 3'b111) ? m_frm : f3;
        p_ill = !cmp && (p_rm == 3'd5 || p_rm == 3'd6 || p_rm == 3'd7);
    endtask

    task automatic tick();
        logic [69:0] r;
        predict();
        r = p_gid ? fake_fpu(req1_func7, p_rm, req1_rs2, req1_a, req1_b)
                  : fake_fpu(req0_func7, p_rm, req0_rs2, req0_a, req0_b);
        @(posedge clk);
        if (rst) begin
            {m_valid, m_id, m_cmp, m_ill, m_fav, m_tag, m_res, m_flags, m_fflags, m_frm} = '0;
            m_cnt = 0;
        end else begin
            m_fflags = (csr_we ? csr_fflags_wdata : m_fflags) | ((p_acc && !p_ill) ? r[5:1] : 5'd0);
            if (csr_we) m_frm = csr_frm_wdata;
            if (p_acc) begin
                m_valid = 1'b1;
                m_id = p_gid;
                m_tag = p_gid ? req1_tag : req0_tag;
                m_res = p_ill ? 64'd0 : r[69:6];
                m_flags = p_ill ? 5'd0 : r[5:1];
                m_cmp = p_ill ? 1'b0 : r[0];
                m_ill = p_ill;
                m_fav = !p_gid;
                if (m_cnt < 65535) m_cnt++;
            end else if (resp_ready) m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic clear();
        {req0_valid, req1_valid, csr_we, rst} = '0;
        {req0_func7, req0_func3, req0_rs2, req0_a, req0_b, req0_tag} = '0;
        {req1_func7, req1_func3, req1_rs2, req1_a, req1_b, req1_tag} = '0;
        csr_frm_wdata = '0;
        csr_fflags_wdata = '0;
        resp_ready = 1'b1;
    endtask

    task automatic put0(input logic [6:0] f7, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag);
        req0_valid = 1'b1; req0_func7 = f7; req0_func3 = f3; req0_a = a; req0_b = b; req0_tag = tag; req0_rs2 = '0;
    endtask

    task automatic test_reset();
        clear();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({resp_valid, resp_id, resp_tag, resp_result, resp_flags, resp_cmp, resp_illegal, frm, fflags, issue_cnt} !== '0)
            $display("FAIL reset: resp_valid=%b result=%h frm=%h fflags=%h cnt=%0d, want all zero",
                     resp_valid, resp_result, frm, fflags, issue_cnt);
        else pass_cnt++;
    endtask

    task automatic test_fadd();
        clear();
        put0(FADD_S, 3'b000, 64'h3F800000, 64'h40000000, 4'd3);
        tick();
        req0_valid = 1'b0;
        total_cnt++;
        if ({resp_valid, resp_id, resp_tag, resp_result, resp_flags, fflags} !== {1'b1, 1'b0, 4'd3, 64'h40400000, 5'd0, 5'd0})
            $display("FAIL fadd: v=%b id=%b tag=%h res=%h fl=%b ff=%b, want 1 0 3 40400000 0 0",
                     resp_valid, resp_id, resp_tag, resp_result, resp_flags, fflags);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (resp_valid !== 1'b0) $display("FAIL fadd_retire: resp_valid=%b want 0", resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_flags();
        clear();
        put0(FADD_S, 3'b000, 64'h7F7FFFFF, 64'h7F7FFFFF, 4'd5);
        tick();
        total_cnt++;
        if ({resp_result, resp_flags, fflags} !== {64'h7F800000, 5'b00101, 5'b00101})
            $display("FAIL overflow: res=%h fl=%b ff=%b, want 7f800000 00101 00101", resp_result, resp_flags, fflags);
        else pass_cnt++;
        put0(FADD_S, 3'b000, 64'h3F800000, 64'h33800000, 4'd6);
        csr_we = 1'b1; csr_fflags_wdata = 5'd0; csr_frm_wdata = 3'b000;
        tick();
        clear();
        total_cnt++;
        if ({fflags, resp_flags} !== {5'b00001, 5'b00001})
            $display("FAIL csr_clear_accum: ff=%b fl=%b, want 00001 00001", fflags, resp_flags);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_dyn_rm();
        clear();
        csr_we = 1'b1; csr_frm_wdata = 3'b010; csr_fflags_wdata = m_fflags;
        tick();
        csr_we = 1'b0;
        put0(FADD_S, 3'b111, 64'h1234, 64'h5678, 4'd1);
        #1;
        total_cnt++;
        if (fpu_func3 !== 3'b010) $display("FAIL dyn_rm: fpu_func3=%b want 010", fpu_func3);
        else pass_cnt++;
        tick();
        req0_valid = 1'b0;
        csr_we = 1'b1; csr_frm_wdata = 3'b101; csr_fflags_wdata = m_fflags;
        tick();
        csr_we = 1'b0;
        put0(FADD_S, 3'b111, 64'h7F7FFFFF, 64'h7F7FFFFF, 4'd2);
        tick();
        total_cnt++;
        if ({resp_valid, resp_illegal, resp_result, resp_flags, fflags, frm} !== {1'b1, 1'b1, 64'd0, 5'd0, m_fflags, 3'b101})
            $display("FAIL illegal_rm: v=%b ill=%b res=%h fl=%b ff=%b frm=%b, want 1 1 0 0 %b 101",
                     resp_valid, resp_illegal, resp_result, resp_flags, fflags, frm, m_fflags);
        else pass_cnt++;
        put0(FCMP_S, 3'b111, 64'h10, 64'h20, 4'd7);
        #1;
        total_cnt++;
        if (fpu_func3 !== 3'b111) $display("FAIL fcmp_passthru: fpu_func3=%b want 111", fpu_func3);
        else pass_cnt++;
        tick();
        req0_valid = 1'b0;
        total_cnt++;
        if ({resp_illegal, resp_cmp, resp_tag} !== {1'b0, 1'b1, 4'd7})
            $display("FAIL fcmp_legal: ill=%b cmp=%b tag=%h, want 0 1 7", resp_illegal, resp_cmp, resp_tag);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_id = 1'b0;
        for (int i = 0; i < 6; i++) begin
            put0(7'h01, 3'b000, 64'(i), 64'(i * 3), 4'(2 * i));
            req1_valid = 1'b1; req1_func7 = 7'h02; req1_func3 = 3'b001; req1_a = 64'(100 + i); req1_tag = 4'(2 * i + 1);
            #1;
            total_cnt++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01))
                $display("FAIL rr_grant[%0d]: ready1/0=%b%b want grant %0d", i, req1_ready, req0_ready, exp_id);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({resp_valid, resp_id, resp_tag} !== {1'b1, exp_id, exp_id ? 4'(2 * i + 1) : 4'(2 * i)})
                $display("FAIL rr_resp[%0d]: v=%b id=%b tag=%h want id %0d", i, resp_valid, resp_id, resp_tag, exp_id);
            else pass_cnt++;
            exp_id = !exp_id;
        end
    endtask

    task automatic test_hold();
        logic [75:0] snap;
        resp_ready = 1'b0;
        snap = {resp_id, resp_tag, resp_result, resp_flags, resp_cmp, resp_illegal};
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL hold_ready[%0d]: %b%b want 00", i, req0_ready, req1_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({resp_valid, resp_id, resp_tag, resp_result, resp_flags, resp_cmp, resp_illegal} !== {1'b1, snap})
                $display("FAIL hold_stable[%0d]: v=%b tag=%h res=%h changed", i, resp_valid, resp_tag, resp_result);
            else pass_cnt++;
        end
        resp_ready = 1'b1;
        predict();
        tick();
        total_cnt++;
        if ({resp_valid, resp_id, resp_tag, resp_result} !== {1'b1, m_id, m_tag, m_res} || m_id !== p_gid)
            $display("FAIL hold_release: v=%b id=%b tag=%h res=%h want 1 %b %h %h",
                     resp_valid, resp_id, resp_tag, resp_result, m_id, m_tag, m_res);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        total_cnt++;
        if (resp_valid !== 1'b1) $display("FAIL pre_reset_valid: resp_valid=%b want 1", resp_valid);
        else pass_cnt++;
        clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({resp_valid, frm, fflags, issue_cnt} !== '0)
            $display("FAIL reset_mid: v=%b frm=%b ff=%b cnt=%0d want all zero", resp_valid, frm, fflags, issue_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        clear();
        for (int i = 0; i < 400; i++) begin
            req0_valid = $urandom_range(0, 2) != 0;
            req1_valid = $urandom_range(0, 2) != 0;
            req0_func7 = ($urandom_range(0, 3) == 0) ? FCMP_S : 7'($urandom);
            req1_func7 = ($urandom_range(0, 3) == 0) ? 7'h51 : 7'($urandom);
            req0_func3 = 3'($urandom); req1_func3 = 3'($urandom);
            req0_rs2 = 5'($urandom); req1_rs2 = 5'($urandom);
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            req0_tag = 4'($urandom); req1_tag = 4'($urandom);
            resp_ready = $urandom_range(0, 3) != 0;
            csr_we = $urandom_range(0, 7) == 0;
            csr_frm_wdata = 3'($urandom); csr_fflags_wdata = 5'($urandom);
            #1;
            predict();
            total_cnt++;
            if ({req1_ready, req0_ready, fpu_func3} !== {p_acc & p_gid, p_acc & !p_gid, p_any ? p_rm : 3'd0})
                $display("FAIL rand_issue[%0d]: r1=%b r0=%b f3=%b want %b %b %b", i, req1_ready, req0_ready,
                         fpu_func3, p_acc & p_gid, p_acc & !p_gid, p_rm);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({resp_valid, frm, fflags, issue_cnt} !== {m_valid, m_frm, m_fflags, 16'(m_cnt)} ||
                (m_valid && {resp_id, resp_tag, resp_result, resp_flags, resp_cmp, resp_illegal} !==
                            {m_id, m_tag, m_res, m_flags, m_cmp, m_ill}))
                $display("FAIL rand_resp[%0d]: v=%b id=%b tag=%h res=%h fl=%b ill=%b ff=%b cnt=%0d want %b %b %h %h %b %b %b %0d",
                         i, resp_valid, resp_id, resp_tag, resp_result, resp_flags, resp_illegal, fflags, issue_cnt,
                         m_valid, m_id, m_tag, m_res, m_flags, m_ill, m_fflags, m_cnt);
            else pass_cnt++;
        end
        clear();
        tick();
    endtask

    task automatic test_saturate();
        clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put0(7'h01, 3'b000, 64'd1, 64'd2, 4'd0);
        for (int i = 0; i < (1 << CNT_W) + 2; i++) tick();
        req0_valid = 1'b0;
        total_cnt++;
        if (issue_cnt !== {CNT_W{1'b1}} || m_cnt != 65535)
            $display("FAIL saturate: issue_cnt=%h want ffff", issue_cnt);
        else pass_cnt++;
    endtask

    initial begin
        {m_valid, m_id, m_cmp, m_ill, m_fav, m_tag, m_res, m_flags, m_fflags, m_frm} = '0;
        m_cnt = 0;
        test_reset();
        test_fadd();
        test_flags();
        test_dyn_rm();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
